can_tx_framer: RTL and testbench
================================

Name: can_tx_framer

Overview:
- Transmit-side CAN 2.0A data-frame serializer. It takes one frame via a valid/ready handshake and drives it onto the bus data line, one bit per clock.
- Handles SOF, arbitration, control and data fields, CRC-15, bit stuffing, the delimiters, the ACK slot, EOF and intermission.
- Generates the BIT_CHK and ACK qualifier strobes consumed by the bus assertion monitor. Samples the wired bus back during the ACK slot.

Parameters:
- MAX_DLC_BYTES, 8, cap on data bytes sent; DLC > 8 is sent as coded but transmits 8 bytes.
- MAX_RETRY, 3, retransmission limit (only with the optional feature).

Ports:
- clock  in  1  single system clock; one CAN bit per cycle.
- reset  in  1  synchronous, active-high.
- frame_valid  in  1  frame offered.
- frame_ready  out  1  framer can accept (IDLE only).
- frame_id  in  11  standard identifier, MSB sent first.
- frame_dlc  in  4  data length code.
- frame_data  in  64  byte0 = [63:56], sent first, MSB first.
- tx_bit  out  1  drives the bus data net; 1 = recessive.
- bus_rx  in  1  wired-AND bus value sampled back.
- bit_chk  out  1  high while the stuffed region is on the bus.
- ack  out  1  one-cycle strobe coincident with the CRC delimiter bit.
- busy  out  1  frame in flight (SOF through intermission).
- tx_done  out  1  one-cycle pulse after the last intermission bit.
- ack_err  out  1  one-cycle pulse, ACK slot sampled recessive.

Behaviour:
- Reset values (registered outputs):
  - tx_bit = 1, bit_chk = 0, ack = 0, busy = 0, tx_done = 0, ack_err = 0.
  - frame_ready = 1 in the cycle after reset deasserts.
  - Reset mid-frame aborts immediately; tx_bit is recessive on the next cycle.
- Handshake:
  - Transfer occurs when frame_valid && frame_ready.
  - Inputs are latched on the transfer cycle.
  - SOF appears on tx_bit the following cycle (latency 1).
  - frame_ready = 0 from the transfer cycle until IDLE is re-entered.
- State machine: IDLE -> HDR -> DATA -> CRC -> CRC_DEL -> ACK_SLOT -> ACK_DEL -> EOF -> IFS -> IDLE.
  - HDR: 19 bits = SOF 0, ID[10:0], RTR 0, IDE 0, r0 0, DLC[3:0].
  - DATA: min(DLC, 8)×8 bits; the state is skipped when DLC = 0.
  - CRC: 15 bits.
  - CRC_DEL, ACK_SLOT, ACK_DEL: 1 bit each.
  - EOF: 7 bits. IFS: 3 bits.
  - A field bit counter sized 7 bits is reloaded on each state entry.
- CRC:
  - CRC-15, polynomial 0x4599, init 0.
  - Computed over unstuffed SOF through the last data bit. Stuff bits are excluded.
- Stuffing:
  - Applies from SOF through the last CRC bit.
  - After 5 consecutive equal bits on tx_bit (stuff bits included in the count), the complement is inserted.
  - While a stuff bit is inserted, the field counter and CRC are frozen.
  - A stuff bit due after the 15th CRC bit is inserted before CRC_DEL.
- bit_chk: high from the SOF cycle through the last CRC or trailing stuff bit; low from CRC_DEL onward.
- ack: high only in the CRC_DEL cycle (tx_bit = 1).
- ACK slot:
  - tx_bit = 1 and bus_rx is sampled.
  - If bus_rx = 1, ack_err pulses in the ACK_DEL cycle. The frame still completes EOF/IFS.
- After IFS, tx_done pulses for one cycle together with the return to IDLE; frame_ready = 1 that cycle.
- frame_valid held high continuously: the next transfer happens in the first IDLE cycle. There are no back-to-back frames without IFS.
- Inputs changing while busy are ignored.

Optional Feature:
- CAN_TX_RETRY_EN defined:
  - On ack_err, after IFS the latched frame is retransmitted without returning to IDLE (frame_ready stays 0).
  - This repeats up to MAX_RETRY times. tx_done pulses only on the final attempt (acked or retries exhausted).
  - A 2-bit retry counter is cleared on a new transfer.
- Undefined: a frame is sent once; ack_err pulses and the frame is dropped.

Decomposition:
- Package can_pkg:
  - tx_state_t enum.
  - Field lengths: HDR_BITS = 19, CRC_BITS = 15, EOF_BITS = 7, IFS_BITS = 3, STUFF_LIMIT = 5.
  - CRC15_POLY = 15'h4599.
  - RECESSIVE = 1'b1.
- Sub-module can_crc15: serial CRC register with clear/enable/data-in inputs and a 15-bit output. It is reused by the receiver.

Test Plan:
- Reset held 3 cycles, then released -> tx_bit = 1, bit_chk = 0, frame_ready = 1 on the first post-reset cycle.
- ID 0x000, DLC 0, bus_rx tied to tx_bit except 0 in ACK_SLOT ->
  - 34 unstuffed zero bits (CRC = 0) with 6 stuff 1s inserted; bit_chk high exactly 40 cycles.
  - ack at cycle 41 after SOF; 53 busy cycles; tx_done once; ack_err never.
- ID 0x7FF, DLC 0 -> stuff 0 inserted after SOF+5 ID ones? No: SOF 0 then 11 ones -> stuff 0 after the 5th and 10th one; no run of 6 equal bits within the bit_chk window.
- ID 0x123, DLC 2, data 0xA55A… -> transmitted data bits 1010_0101_0101_1010; CRC field matches the reference model; EOF 7 ones follow ACK_DEL.
- ACK slot left recessive -> ack_err pulse in ACK_DEL cycle. Without CAN_TX_RETRY_EN: 1 frame. With it: 4 total frames, then tx_done.
- Reset asserted during DATA -> next cycle tx_bit = 1, busy = 0, bit_chk = 0, no tx_done; a new frame is accepted afterward.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN 2.0A definitions: transmit state encoding, field lengths, CRC-15 polynomial
// and a helper that turns a DLC into the number of data bits actually sent.
package can_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK_SLOT,
        ST_ACK_DEL,
        ST_EOF,
        ST_IFS
    } tx_state_t;

    localparam int HDR_BITS    = 19;
    localparam int CRC_BITS    = 15;
    localparam int EOF_BITS    = 7;
    localparam int IFS_BITS    = 3;
    localparam int STUFF_LIMIT = 5;

    localparam logic [14:0] CRC15_POLY = 15'h4599;
    localparam logic        RECESSIVE  = 1'b1;

    // DLC values above the byte cap are sent as coded but only carry cap_bytes of data.
    function automatic logic [6:0] data_bits(input logic [3:0] dlc, input int cap_bytes);
        int bytes;
        bytes = (int'(dlc) > cap_bytes) ? cap_bytes : int'(dlc);
        return 7'(bytes * 8);
    endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register, one bit per enabled clock; shared by the transmit and receive paths.
module can_crc15
    import can_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        din,
    output logic [14:0] crc
);

    logic feedback;

    assign feedback = crc[14] ^ din;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[13:0], 1'b0} ^ (feedback ? CRC15_POLY : 15'h0000);
        end
    end

endmodule

// File: rtl/can_tx_framer.sv
// CAN 2.0A data-frame transmitter: one bus bit per clock, bit stuffing, CRC-15, ACK sampling.
// Build option CAN_TX_RETRY_EN: retransmit an unacknowledged frame up to MAX_RETRY times.
module can_tx_framer
    import can_pkg::*;
#(
    parameter int MAX_DLC_BYTES = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [10:0] frame_id,
    input  logic [3:0]  frame_dlc,
    input  logic [63:0] frame_data,
    output logic        tx_bit,
    input  logic        bus_rx,
    output logic        bit_chk,
    output logic        ack,
    output logic        busy,
    output logic        tx_done,
    output logic        ack_err
);

`ifdef CAN_TX_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    tx_state_t   state;
    logic [6:0]  cnt;
    logic [2:0]  run_len;
    logic [10:0] id_q;
    logic [3:0]  dlc_q;
    logic [63:0] data_q;
    logic [6:0]  nbits_q;
    logic        nack_q;
    logic [1:0]  retry_cnt;

    logic [17:0] hdr_vec;
    logic        in_stuff;
    logic        do_stuff;
    tx_state_t   adv_state;
    logic [6:0]  adv_cnt;
    logic        adv_bit;
    logic        accept;
    logic        frame_end;
    logic        retry_now;
    logic        crc_en;
    logic        crc_clear;
    logic [14:0] crc_val;

    // state/cnt describe the bit currently on tx_bit; adv_* is the next unstuffed bit.
    always_comb begin
        hdr_vec   = {id_q, 3'b000, dlc_q};
        in_stuff  = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CRC);
        do_stuff  = in_stuff && (run_len == 3'(STUFF_LIMIT));
        adv_state = state;
        adv_cnt   = cnt + 7'd1;
        adv_bit   = RECESSIVE;
        case (state)
            ST_HDR: begin
                if (cnt == 7'(HDR_BITS - 1)) begin
                    adv_cnt = '0;
                    if (nbits_q == '0) begin
                        adv_state = ST_CRC;
                        adv_bit   = crc_val[14];
                    end else begin
                        adv_state = ST_DATA;
                        adv_bit   = data_q[63];
                    end
                end else begin
                    adv_bit = hdr_vec[5'd17 - cnt[4:0]];
                end
            end
            ST_DATA: begin
                if (cnt == nbits_q - 7'd1) begin
                    adv_state = ST_CRC;
                    adv_cnt   = '0;
                    adv_bit   = crc_val[14];
                end else begin
                    adv_bit = data_q[6'd62 - cnt[5:0]];
                end
            end
            ST_CRC: begin
                if (cnt == 7'(CRC_BITS - 1)) begin
                    adv_state = ST_CRC_DEL;
                    adv_cnt   = '0;
                end else begin
                    adv_bit = crc_val[4'd13 - cnt[3:0]];
                end
            end
            ST_CRC_DEL: begin
                adv_state = ST_ACK_SLOT;
                adv_cnt   = '0;
            end
            ST_ACK_SLOT: begin
                adv_state = ST_ACK_DEL;
                adv_cnt   = '0;
            end
            ST_ACK_DEL: begin
                adv_state = ST_EOF;
                adv_cnt   = '0;
            end
            ST_EOF: begin
                if (cnt == 7'(EOF_BITS - 1)) begin
                    adv_state = ST_IFS;
                    adv_cnt   = '0;
                end
            end
            ST_IFS: begin
                if (cnt == 7'(IFS_BITS - 1)) begin
                    adv_state = ST_IDLE;
                    adv_cnt   = '0;
                end
            end
            default: begin
                adv_state = ST_IDLE;
                adv_cnt   = '0;
            end
        endcase
        accept    = (state == ST_IDLE) && frame_valid && frame_ready;
        frame_end = (state == ST_IFS) && (cnt == 7'(IFS_BITS - 1));
        retry_now = RETRY_EN && frame_end && nack_q && (int'(retry_cnt) < MAX_RETRY);
        // SOF is a zero shifted into a zero register, so clearing at frame start covers it.
        crc_clear = accept || retry_now;
        crc_en    = !do_stuff && ((adv_state == ST_HDR) || (adv_state == ST_DATA));
    end

    can_crc15 u_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (crc_en),
        .din    (adv_bit),
        .crc    (crc_val)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            run_len     <= '0;
            id_q        <= '0;
            dlc_q       <= '0;
            data_q      <= '0;
            nbits_q     <= '0;
            nack_q      <= 1'b0;
            retry_cnt   <= '0;
            tx_bit      <= RECESSIVE;
            bit_chk     <= 1'b0;
            ack         <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            ack_err     <= 1'b0;
            frame_ready <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            ack_err <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    id_q        <= frame_id;
                    dlc_q       <= frame_dlc;
                    data_q      <= frame_data;
                    nbits_q     <= data_bits(frame_dlc, MAX_DLC_BYTES);
                    retry_cnt   <= '0;
                    nack_q      <= 1'b0;
                    frame_ready <= 1'b0;
                    state       <= ST_HDR;
                    cnt         <= '0;
                    tx_bit      <= 1'b0;
                    run_len     <= 3'd1;
                    bit_chk     <= 1'b1;
                    busy        <= 1'b1;
                end
            end else if (do_stuff) begin
                tx_bit  <= ~tx_bit;
                run_len <= 3'd1;
            end else if (retry_now) begin
                retry_cnt <= retry_cnt + 2'd1;
                nack_q    <= 1'b0;
                state     <= ST_HDR;
                cnt       <= '0;
                tx_bit    <= 1'b0;
                run_len   <= 3'd1;
                bit_chk   <= 1'b1;
            end else begin
                state   <= adv_state;
                cnt     <= adv_cnt;
                tx_bit  <= adv_bit;
                run_len <= (adv_bit == tx_bit) ? run_len + 3'd1 : 3'd1;
                bit_chk <= (adv_state == ST_HDR) || (adv_state == ST_DATA) || (adv_state == ST_CRC);
                ack     <= (adv_state == ST_CRC_DEL);
                busy    <= (adv_state != ST_IDLE);
                if (state == ST_ACK_SLOT) begin
                    nack_q  <= bus_rx;
                    ack_err <= bus_rx;
                end
                if (adv_state == ST_IDLE) begin
                    tx_done     <= 1'b1;
                    frame_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_tx_framer.sv
// Self-checking bench for can_tx_framer: random frames against a queue-based frame model.
module tb_can_tx_framer;

`ifdef CAN_TX_RETRY_EN
    localparam int NACK_ATTEMPTS = 4;
`else
    localparam int NACK_ATTEMPTS = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [10:0] frame_id = '0;
    logic [3:0]  frame_dlc = '0;
    logic [63:0] frame_data = '0;
    logic        tx_bit;
    logic        bus_rx;
    logic        bit_chk;
    logic        ack;
    logic        busy;
    logic        tx_done;
    logic        ack_err;
    logic        ack_dom = 1'b0;

    int checks = 0;
    int errors = 0;

    logic exp_q[$];
    logic obs_q[$];
    int   exp_stuffed;
    int   m_bc, m_ack_idx, m_busy, m_done, m_err;

    always #5 clock = ~clock;

    // Wired-AND bus: a remote receiver pulls the line dominant in the ACK slot when asked.
    assign bus_rx = tx_bit & ~ack_dom;

    can_tx_framer dut (
        .clock       (clock),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_id    (frame_id),
        .frame_dlc   (frame_dlc),
        .frame_data  (frame_data),
        .tx_bit      (tx_bit),
        .bus_rx      (bus_rx),
        .bit_chk     (bit_chk),
        .ack         (ack),
        .busy        (busy),
        .tx_done     (tx_done),
        .ack_err     (ack_err)
    );

    // Builds the expected tx_bit sequence of one attempt from the frame rules.
    task automatic build_model(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        logic        raw[$];
        logic [14:0] crc;
        logic        fb;
        logic        last;
        int          nbytes;
        int          run;
        raw = {};
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        repeat (3) raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nbytes = (int'(dlc) > 8) ? 8 : int'(dlc);
        for (int i = 0; i < nbytes * 8; i++) raw.push_back(data[63 - i]);
        crc = '0;
        foreach (raw[i]) begin
            fb  = crc[14] ^ raw[i];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        exp_q = {};
        run   = 0;
        last  = 1'b0;
        foreach (raw[i]) begin
            if (exp_q.size() > 0 && raw[i] == last) run++;
            else run = 1;
            exp_q.push_back(raw[i]);
            last = raw[i];
            if (run == 5) begin
                exp_q.push_back(~raw[i]);
                last = ~raw[i];
                run  = 1;
            end
        end
        exp_stuffed = exp_q.size();
        repeat (13) exp_q.push_back(1'b1);
    endtask

    task automatic run_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                             input bit acked, input string name);
        int         total, attempts, guard, s_len;
        logic [6:0] obs, exp;
        build_model(id, dlc, data);
        s_len    = exp_stuffed;
        total    = exp_q.size();
        attempts = acked ? 1 : NACK_ATTEMPTS;
        obs_q    = {};
        m_bc = 0; m_ack_idx = -1; m_busy = 0; m_done = 0; m_err = 0;
        guard = 0;
        while (frame_ready !== 1'b1 && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: frame_ready=%b required 1", name, frame_ready);
            return;
        end
        frame_id    = id;
        frame_dlc   = dlc;
        frame_data  = data;
        frame_valid = 1'b1;
        for (int a = 0; a < attempts; a++) begin
            for (int k = 0; k < total; k++) begin
                @(negedge clock);
                if (a == 0 && k == 0) begin
                    frame_valid = 1'b0;
                    frame_id    = 11'($urandom);
                    frame_dlc   = 4'($urandom);
                    frame_data  = {$urandom, $urandom};
                end
                obs = {tx_bit, bit_chk, ack, busy, tx_done, ack_err, frame_ready};
                exp = {exp_q[k], 1'(k < s_len), 1'(k == s_len), 1'b1, 1'b0,
                       1'(!acked && k == s_len + 2), 1'b0};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s attempt %0d bit %0d: {tx,chk,ack,busy,done,err,rdy}=%b required %b",
                             name, a, k, obs, exp);
                end
                if (a == 0) begin
                    obs_q.push_back(tx_bit);
                    if (bit_chk === 1'b1) m_bc++;
                    if (ack === 1'b1 && m_ack_idx < 0) m_ack_idx = k;
                end
                if (busy === 1'b1) m_busy++;
                if (tx_done === 1'b1) m_done++;
                if (ack_err === 1'b1) m_err++;
                ack_dom = acked && (k == s_len + 1);
            end
        end
        @(negedge clock);
        ack_dom = 1'b0;
        if (tx_done === 1'b1) m_done++;
        if (busy === 1'b1) m_busy++;
        obs = {tx_bit, bit_chk, ack, busy, tx_done, ack_err, frame_ready};
        checks++;
        if (obs !== 7'b1000101) begin
            errors++;
            $display("FAIL %s done_cycle: {tx,chk,ack,busy,done,err,rdy}=%b required 1000101", name, obs);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({tx_bit, bit_chk, ack, busy, tx_done, ack_err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_values: {tx,chk,ack,busy,done,err}=%b required 100000",
                     {tx_bit, bit_chk, ack, busy, tx_done, ack_err});
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({tx_bit, bit_chk, frame_ready} !== 3'b101) begin
            errors++;
            $display("FAIL post_reset: {tx,chk,rdy}=%b required 101", {tx_bit, bit_chk, frame_ready});
        end
    endtask

    task automatic test_zero_frame();
        run_frame(11'h000, 4'd0, 64'h0, 1'b1, "zero_frame");
        checks++;
        if (m_bc != 40) begin errors++; $display("FAIL zero_bitchk_len: %0d required 40", m_bc); end
        checks++;
        if (m_ack_idx != 40) begin errors++; $display("FAIL zero_ack_pos: %0d required 40", m_ack_idx); end
        checks++;
        if (m_busy != 53) begin errors++; $display("FAIL zero_busy_len: %0d required 53", m_busy); end
        checks++;
        if (m_done != 1) begin errors++; $display("FAIL zero_done_cnt: %0d required 1", m_done); end
        checks++;
        if (m_err != 0) begin errors++; $display("FAIL zero_ack_err_cnt: %0d required 0", m_err); end
    endtask

    task automatic test_all_ones();
        int run, max_run;
        run_frame(11'h7FF, 4'd0, {$urandom, $urandom}, 1'b1, "all_ones");
        checks++;
        if (obs_q.size() < 13 || obs_q[6] !== 1'b0 || obs_q[12] !== 1'b0) begin
            errors++;
            $display("FAIL ones_stuff_pos: bits6/12 not both stuff zeros (size %0d)", obs_q.size());
        end
        run = 0;
        max_run = 0;
        for (int i = 0; i < m_bc && i < obs_q.size(); i++) begin
            if (i > 0 && obs_q[i] == obs_q[i - 1]) run++;
            else run = 1;
            if (run > max_run) max_run = run;
        end
        checks++;
        if (max_run > 5) begin errors++; $display("FAIL ones_max_run: %0d required <= 5", max_run); end
    endtask

    task automatic test_data_pattern();
        logic        dst[$];
        logic        last;
        logic [15:0] dbits;
        int          run, skip, ones;
        run_frame(11'h123, 4'd2, {16'hA55A, 16'($urandom), $urandom}, 1'b1, "data_pattern");
        dst = {}; run = 0; skip = 0; last = 1'b0;
        for (int i = 0; i < m_bc && i < obs_q.size(); i++) begin
            if (skip != 0) begin
                skip = 0; run = 1; last = obs_q[i];
            end else begin
                if (i > 0 && obs_q[i] == last) run++;
                else run = 1;
                last = obs_q[i];
                dst.push_back(obs_q[i]);
                if (run == 5) skip = 1;
            end
        end
        dbits = '0;
        for (int i = 19; i < 35 && i < dst.size(); i++) dbits = {dbits[14:0], dst[i]};
        checks++;
        if (dbits !== 16'hA55A) begin errors++; $display("FAIL data_bits: %h required a55a", dbits); end
        ones = 0;
        for (int i = m_bc + 3; i < m_bc + 10 && i < obs_q.size(); i++) if (obs_q[i] === 1'b1) ones++;
        checks++;
        if (ones != 7) begin errors++; $display("FAIL eof_ones: %0d required 7", ones); end
    endtask

    task automatic test_nack();
        run_frame(11'($urandom), 4'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b0, "nack");
        checks++;
        if (m_err != NACK_ATTEMPTS) begin
            errors++;
            $display("FAIL nack_err_cnt: %0d required %0d", m_err, NACK_ATTEMPTS);
        end
        checks++;
        if (m_done != 1) begin errors++; $display("FAIL nack_done_cnt: %0d required 1", m_done); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            run_frame(11'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                      $urandom_range(0, 3) != 0, "random");
        end
    endtask

    task automatic test_reset_mid();
        frame_id    = 11'($urandom);
        frame_dlc   = 4'd8;
        frame_data  = {$urandom, $urandom};
        frame_valid = 1'b1;
        @(negedge clock);
        frame_valid = 1'b0;
        repeat (30) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({tx_bit, busy, bit_chk, tx_done} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_reset: {tx,busy,chk,done}=%b required 1000", {tx_bit, busy, bit_chk, tx_done});
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({frame_ready, tx_done} !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset_release: {rdy,done}=%b required 10", {frame_ready, tx_done});
        end
        run_frame(11'($urandom), 4'($urandom_range(1, 8)), {$urandom, $urandom}, 1'b1, "after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_frame();
        test_all_ones();
        test_data_pattern();
        test_nack();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
